serial_addsub: RTL and testbench
================================

// Module: serial_addsub
// PURPOSE
//   Bit-serial two's-complement adder/subtractor built around one full-adder cell and a carry flop.
//   Accepts two WIDTH-bit operands with a start pulse and streams them LSB-first through the cell,
//   one bit per clock. Returns a registered result with carry-out and signed-overflow flags.
//   Sits behind the tt_um_* top as the sequential counterpart of the combinational full-adder cell.
// PARAMETERS
//   WIDTH   8   operand/result width in bits; legal range >= 2
// PORTS
//   clk      in   1      clock; all state updates on posedge
//   rst_n    in   1      asynchronous reset, active-low
//   start    in   1      request; sampled only in IDLE
//   sub      in   1      0: a+b, 1: a-b; captured with start
//   a        in   WIDTH  operand A; captured with start
//   b        in   WIDTH  operand B; captured with start
//   busy     out  1      high while bits are being processed (RUN)
//   done     out  1      one-cycle pulse: result/flags valid
//   result   out  WIDTH  sum/difference; held until next completion
//   cout     out  1      final carry; in sub mode 1 = no borrow
//   ovf      out  1      signed overflow = carry into MSB ^ carry out of MSB
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=IDLE; busy, done, result, cout, ovf, carry and bit counter all 0.
//     Takes effect immediately, including mid-RUN. A partial result is discarded and no done follows.
//   - FSM: IDLE -> RUN -> DONE -> IDLE.
//     IDLE: start=1 at edge E0 loads opA=a, opB = sub ? ~b : b, carry = sub, count=0; next state RUN.
//     RUN: at each edge E1..E_WIDTH:
//       s = opA[0]^opB[0]^carry
//       carry <= majority(opA[0], opB[0], carry)
//       s shifts into the MSB of the sum shift register
//       opA and opB shift right; count increments
//       At the last bit (count==WIDTH-1), the pre-update carry is saved as carry-into-MSB.
//       After E_WIDTH: state=DONE.
//     DONE: result/cout/ovf registers are loaded on entry. done=1 for exactly one cycle. Next state IDLE.
//   - Latency: done asserted WIDTH+1 cycles after the start edge. busy=1 for exactly WIDTH cycles.
//     Throughput: one operation per WIDTH+2 cycles.
//   - start while RUN or DONE: ignored, not queued; operands and sub are not re-captured.
//   - result/cout/ovf change only on DONE entry or reset; stable during RUN of the next operation.
//   - Arithmetic is modulo 2^WIDTH. cout and ovf together give unsigned and signed status.
//   - a/b/sub may change freely after the capture edge.
// CONFIGURATION
//   SERIAL_ADDSUB_ZERO_EN
//     defined: adds output port zero (1 bit), registered with result, = (result==0); reset 0.
//     undefined: zero port and its logic absent; all other behaviour identical.
// TESTING
//   1. Hold rst_n=0 -> busy=done=result=cout=ovf=0; release, idle 5 cycles -> outputs unchanged.
//   2. a=8'h3C b=8'h05 sub=0 start 1 cycle -> busy high 8 cycles; done at +9; result=8'h41 cout=0 ovf=0.
//   3. a=8'hFF b=8'h01 add -> result=8'h00 cout=1 ovf=0; then a=8'h7F b=8'h01 add -> 8'h80 cout=0 ovf=1.
//   4. a=8'h05 b=8'h07 sub=1 -> 8'hFE cout=0 ovf=0; a=8'h80 b=8'h01 sub=1 -> 8'h7F cout=1 ovf=1.
//   5. start a=8'h10 b=8'h20; during RUN pulse start with a=8'hAA b=8'h55 -> single done, result=8'h30.
//   6. rst_n=0 at 4th RUN cycle -> immediate busy=0, outputs 0, no done; next start 8'h01+8'h01 -> 8'h02.
//   (ZERO_EN) test 3 first case -> zero=1 with done; test 2 -> zero=0.

Source files
------------

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor: one full-adder cell, one carry flop,
// operands streamed LSB-first, one bit per clock.
// Optional feature macro: SERIAL_ADDSUB_ZERO_EN adds a registered 'zero' flag output.
module serial_addsub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
`ifdef SERIAL_ADDSUB_ZERO_EN
  ,
  output logic             zero
`endif
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] op_a, op_a_nxt;
  logic [WIDTH-1:0] op_b, op_b_nxt;
  logic [WIDTH-1:0] sum_sr, sum_nxt;
  logic             carry, carry_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             busy_nxt, done_nxt;
  logic [WIDTH-1:0] result_nxt;
  logic             cout_nxt, ovf_nxt;
`ifdef SERIAL_ADDSUB_ZERO_EN
  logic             zero_nxt;
`endif

  logic             bit_s;
  logic             bit_c;
  logic [WIDTH-1:0] sum_shift;

  // Full-adder cell on the current LSBs and the shifted-in sum word
  always_comb begin
    bit_s     = op_a[0] ^ op_b[0] ^ carry;
    bit_c     = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
    sum_shift = WIDTH'({bit_s, sum_sr} >> 1);
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt  = state;
    op_a_nxt   = op_a;
    op_b_nxt   = op_b;
    sum_nxt    = sum_sr;
    carry_nxt  = carry;
    count_nxt  = count;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    result_nxt = result;
    cout_nxt   = cout;
    ovf_nxt    = ovf;
`ifdef SERIAL_ADDSUB_ZERO_EN
    zero_nxt   = zero;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          op_a_nxt  = a;
          op_b_nxt  = sub ? ~b : b;
          carry_nxt = sub;
          count_nxt = '0;
          sum_nxt   = '0;
          busy_nxt  = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        sum_nxt   = sum_shift;
        op_a_nxt  = op_a >> 1;
        op_b_nxt  = op_b >> 1;
        carry_nxt = bit_c;
        count_nxt = count + CNT_W'(1);
        if (count == CNT_W'(WIDTH - 1)) begin
          // carry here is still the carry into the MSB
          result_nxt = sum_shift;
          cout_nxt   = bit_c;
          ovf_nxt    = carry ^ bit_c;
`ifdef SERIAL_ADDSUB_ZERO_EN
          zero_nxt   = (sum_shift == '0);
`endif
          busy_nxt   = 1'b0;
          done_nxt   = 1'b1;
          state_nxt  = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      op_a   <= '0;
      op_b   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      count  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
`ifdef SERIAL_ADDSUB_ZERO_EN
      zero   <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      op_a   <= op_a_nxt;
      op_b   <= op_b_nxt;
      sum_sr <= sum_nxt;
      carry  <= carry_nxt;
      count  <= count_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      result <= result_nxt;
      cout   <= cout_nxt;
      ovf    <= ovf_nxt;
`ifdef SERIAL_ADDSUB_ZERO_EN
      zero   <= zero_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: directed cases plus randomized operations,
// expected results queued at issue time and checked by an independent monitor.
module tb_serial_addsub;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             sub = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
`ifdef SERIAL_ADDSUB_ZERO_EN
  logic             zero;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
  } exp_t;

  exp_t             q[$];
  exp_t             mon_e;
  logic [WIDTH-1:0] hold_res;
  logic             hold_cout;
  logic             hold_ovf;
  int               n_checks = 0;
  int               n_fail = 0;

  serial_addsub #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
`ifdef SERIAL_ADDSUB_ZERO_EN
    ,
    .zero   (zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic, signed and unsigned views
  function automatic exp_t model(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input logic ts);
    int   sa, sb, r, ua, ub;
    exp_t e;
    sa = int'($signed(ta));
    sb = int'($signed(tb_));
    ua = int'(ta);
    ub = int'(tb_);
    r  = ts ? (sa - sb) : (sa + sb);
    e.result = WIDTH'(r);
    e.ovf    = (r > 127) || (r < -128);
    e.cout   = ts ? (ua >= ub) : ((ua + ub) > 255);
    return e;
  endfunction

  // Monitor: pops on done, otherwise checks that outputs hold their last value
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      hold_res  = '0;
      hold_cout = 1'b0;
      hold_ovf  = 1'b0;
    end else if (done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'(0));
      end else begin
        mon_e = q.pop_front();
        chk("result", 32'(result), 32'(mon_e.result));
        chk("cout", 32'(cout), 32'(mon_e.cout));
        chk("ovf", 32'(ovf), 32'(mon_e.ovf));
`ifdef SERIAL_ADDSUB_ZERO_EN
        chk("zero", 32'(zero), 32'(mon_e.result == '0));
`endif
        chk("busy_at_done", 32'(busy), 32'(0));
        hold_res  = mon_e.result;
        hold_cout = mon_e.cout;
        hold_ovf  = mon_e.ovf;
      end
    end else begin
      chk("hold_outputs", 32'({result, cout, ovf}), 32'({hold_res, hold_cout, hold_ovf}));
`ifdef SERIAL_ADDSUB_ZERO_EN
      chk("hold_zero", 32'(zero), 32'(hold_res == '0));
`endif
    end
  end

  // One operation; optionally pulses start during RUN and during DONE
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input logic ts,
                        input bit inject);
    int lat;
    int busy_cnt;
    @(negedge clk);
    a = ta;
    b = tb_;
    sub = ts;
    start = 1'b1;
    q.push_back(model(ta, tb_, ts));
    lat = 0;
    busy_cnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (inject && lat == 3) begin
        start = 1'b1;
        a = 8'hAA;
        b = 8'h55;
        sub = 1'($urandom);
      end else begin
        start = 1'b0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        sub = 1'($urandom);
      end
      if (busy) busy_cnt++;
    end while (!done && lat < 40);
    chk("latency", 32'(lat), 32'(WIDTH + 1));
    chk("busy_cycles", 32'(busy_cnt), 32'(WIDTH));
    if (inject) begin
      start = 1'b1;
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_outputs", 32'({busy, done, result, cout, ovf}), 32'(0));
    #11 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_outputs", 32'({busy, done, result, cout, ovf}), 32'(0));

    // Directed cases
    run_op(8'h3C, 8'h05, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0, 1'b0);
    run_op(8'h05, 8'h07, 1'b1, 1'b0);
    run_op(8'h80, 8'h01, 1'b1, 1'b0);
    run_op(8'h10, 8'h20, 1'b0, 1'b1);
    repeat (3) @(negedge clk);

    // Reset during the 4th RUN cycle
    @(negedge clk);
    a = 8'h33;
    b = 8'h44;
    sub = 1'b0;
    start = 1'b1;
    q.push_back(model(8'h33, 8'h44, 1'b0));
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_reset_outputs", 32'({busy, done, result, cout, ovf}), 32'(0));
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("no_done_after_reset", 32'(q.size()), 32'(0));
    run_op(8'h01, 8'h01, 1'b0, 1'b0);

    // Randomized operations, including boundary operands
    for (int i = 0; i < 40; i++) begin
      logic [WIDTH-1:0] ra, rb;
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      if (i % 10 == 0) ra = 8'h80;
      if (i % 10 == 1) rb = 8'h7F;
      if (i % 10 == 2) rb = ra;
      run_op(ra, rb, 1'($urandom), ($urandom_range(0, 3) == 0));
    end

    repeat (4) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
